clock_phase_tracker: RTL and testbench

CLOCK_PHASE_TRACKER -- requirements
Module: clock_phase_tracker

---
 rtl/clock_phase_tracker.sv | 133 +++++++++++++
 tb/tb_clock_phase_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_phase_tracker.sv
// Slow-clock phase/period tracker with lock detection in the CLK domain.
// Optional CLOCK_PHASE_TRACKER_GLITCH_FILTER_EN adds a 2-sample level filter.
module clock_phase_tracker #(
  parameter int CNT_WIDTH  = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CLK_VAL,
  output logic                 RISE_PULSE,
  output logic                 FALL_PULSE,
  output logic [CNT_WIDTH-1:0] PHASE,
  output logic [CNT_WIDTH-1:0] PERIOD,
  output logic                 PERIOD_VLD,
  output logic [CNT_WIDTH-1:0] HIGH_CNT,
  output logic                 LOCKED,
  output logic                 TIMEOUT
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0] LC = MW'(LOCK_COUNT);
  localparam logic [CNT_WIDTH:0] ONE = (CNT_WIDTH+1)'(1);
  localparam logic [CNT_WIDTH:0] TOLW = (CNT_WIDTH+1)'(TOL);
  localparam logic [CNT_WIDTH-1:0] PMAX = '1;
  localparam logic [CNT_WIDTH-1:0] PSAT1 =
    {{(CNT_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ACQUIRE,
    MEASURE,
    TRACK,
    LOCK
  } state_t;

  state_t state, state_nx;
  logic [MW-1:0] mcnt, mcnt_nx;
  logic prev, acc, rise, fall, tmo, match;
  logic [CNT_WIDTH:0] p_new, p_old, diff;

`ifdef CLOCK_PHASE_TRACKER_GLITCH_FILTER_EN
  logic s1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) s1 <= 1'b0;
    else        s1 <= CLK_VAL;
  end

  // a new level must be seen on two consecutive samples
  assign acc = (CLK_VAL == s1) ? CLK_VAL : prev;
`else
  assign acc = CLK_VAL;
`endif

  assign rise = acc & ~prev;
  assign fall = ~acc & prev;
  // a rise on the saturating cycle takes priority
  assign tmo  = ~rise & (PHASE == PSAT1);

  assign p_new = {1'b0, PHASE} + ONE;
  assign p_old = {1'b0, PERIOD};
  assign diff  = (p_new >= p_old) ? p_new - p_old
                                  : p_old - p_new;
  assign match = diff <= TOLW;

  always_comb begin
    state_nx = state;
    mcnt_nx  = mcnt;
    if (rise) begin
      case (state)
        ACQUIRE: state_nx = MEASURE;
        MEASURE: begin
          state_nx = TRACK;
          mcnt_nx  = '0;
        end
        TRACK: begin
          if (!match) begin
            mcnt_nx = '0;
          end else if (mcnt + MW'(1) == LC) begin
            state_nx = LOCK;
            mcnt_nx  = '0;
          end else begin
            mcnt_nx = mcnt + MW'(1);
          end
        end
        LOCK: begin
          if (!match) begin
            state_nx = TRACK;
            mcnt_nx  = '0;
          end
        end
        default: state_nx = ACQUIRE;
      endcase
    end else if (tmo) begin
      state_nx = ACQUIRE;
      mcnt_nx  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ACQUIRE;
      mcnt       <= '0;
      prev       <= 1'b0;
      RISE_PULSE <= 1'b0;
      FALL_PULSE <= 1'b0;
      PHASE      <= '0;
      PERIOD     <= '0;
      PERIOD_VLD <= 1'b0;
      HIGH_CNT   <= '0;
      LOCKED     <= 1'b0;
      TIMEOUT    <= 1'b0;
    end else begin
      state      <= state_nx;
      mcnt       <= mcnt_nx;
      prev       <= acc;
      RISE_PULSE <= rise;
      FALL_PULSE <= fall;
      TIMEOUT    <= tmo;
      LOCKED     <= (state_nx == LOCK);
      PERIOD_VLD <= rise & (state != ACQUIRE);
      if (rise)
        PHASE <= '0;
      else if (PHASE != PMAX)
        PHASE <= PHASE + CNT_WIDTH'(1);
      if (rise && state != ACQUIRE)
        PERIOD <= p_new[CNT_WIDTH-1:0];
      if (fall && state != ACQUIRE)
        HIGH_CNT <= p_new[CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_clock_phase_tracker.sv
// Randomized bench for clock_phase_tracker against a behavioural model.
// Literal checks pin lock, tolerance, timeout, glitch and reset behaviour.
module tb_clock_phase_tracker;

  localparam int W     = 8;
  localparam int LOCKN = 4;
  localparam int TOLV  = 1;
  localparam int ACQ = 0, MEAS = 1, TRK = 2, LCK = 3;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic CLK_VAL = 1'b0;
  logic RISE_PULSE, FALL_PULSE, PERIOD_VLD;
  logic LOCKED, TIMEOUT;
  logic [W-1:0] PHASE, PERIOD, HIGH_CNT;

  int compared = 0;
  int mismatched = 0;
  int tmo_seen = 0;

  int m_prev = 0, m_h1 = 0, m_phase = 0;
  int m_mode = ACQ, m_mcnt = 0;
  int m_period = 0, m_high = 0;
  int e_rp = 0, e_fp = 0, e_pv = 0, e_tmo = 0;

  clock_phase_tracker #(
    .CNT_WIDTH(W), .LOCK_COUNT(LOCKN), .TOL(TOLV)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CLK_VAL(CLK_VAL),
    .RISE_PULSE(RISE_PULSE), .FALL_PULSE(FALL_PULSE),
    .PHASE(PHASE), .PERIOD(PERIOD),
    .PERIOD_VLD(PERIOD_VLD), .HIGH_CNT(HIGH_CNT),
    .LOCKED(LOCKED), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic cmp(input string nm, input int act,
                     input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin : model
    int v, acc, np, d;
    int rise, fall;
    v = int'(CLK_VAL);
    if (!RST_N) begin
      m_prev = 0; m_h1 = 0; m_phase = 0;
      m_mode = ACQ; m_mcnt = 0;
      m_period = 0; m_high = 0;
      e_rp = 0; e_fp = 0; e_pv = 0; e_tmo = 0;
    end else begin
`ifdef CLOCK_PHASE_TRACKER_GLITCH_FILTER_EN
      acc = (v == m_h1) ? v : m_prev;
      m_h1 = v;
`else
      acc = v;
`endif
      rise = (acc == 1 && m_prev == 0) ? 1 : 0;
      fall = (acc == 0 && m_prev == 1) ? 1 : 0;
      m_prev = acc;
      e_pv = 0;
      e_tmo = 0;
      np = m_phase + 1;
      if (fall == 1 && m_mode != ACQ) m_high = np;
      if (rise == 1) begin
        if (m_mode == ACQ) begin
          m_mode = MEAS;
        end else begin
          e_pv = 1;
          d = (np > m_period) ? np - m_period
                              : m_period - np;
          if (m_mode == MEAS || d > TOLV) begin
            m_mode = TRK;
            m_mcnt = 0;
          end else if (m_mode == TRK) begin
            m_mcnt++;
            if (m_mcnt >= LOCKN) m_mode = LCK;
          end
          m_period = np;
        end
        m_phase = 0;
      end else if (m_phase < 255) begin
        m_phase = np;
        if (m_phase == 255) begin
          e_tmo = 1;
          m_mode = ACQ;
          m_mcnt = 0;
        end
      end
      e_rp = rise;
      e_fp = fall;
    end
    #1;
    cmp("rise_pulse", int'(RISE_PULSE), e_rp);
    cmp("fall_pulse", int'(FALL_PULSE), e_fp);
    cmp("phase", int'(PHASE), m_phase);
    cmp("period", int'(PERIOD), m_period);
    cmp("period_vld", int'(PERIOD_VLD), e_pv);
    cmp("high_cnt", int'(HIGH_CNT), m_high);
    cmp("locked", int'(LOCKED), (m_mode == LCK) ? 1 : 0);
    cmp("timeout", int'(TIMEOUT), e_tmo);
    if (TIMEOUT) tmo_seen++;
  end

  task automatic slow(input int hi, input int lo);
    repeat (hi) begin
      @(negedge CLK);
      CLK_VAL = 1'b1;
    end
    repeat (lo) begin
      @(negedge CLK);
      CLK_VAL = 1'b0;
    end
  endtask

  initial begin
    int t0;
    RST_N = 1'b0;
    CLK_VAL = 1'b0;
    repeat (3) @(negedge CLK);
    cmp("lit_rst_phase", int'(PHASE), 0);
    cmp("lit_rst_locked", int'(LOCKED), 0);
    cmp("lit_rst_period", int'(PERIOD), 0);
    RST_N = 1'b1;

    repeat (8) slow(5, 5);
    cmp("lit_lock_period", int'(PERIOD), 10);
    cmp("lit_lock_high", int'(HIGH_CNT), 5);
    cmp("lit_lock", int'(LOCKED), 1);

    slow(5, 7);
    slow(5, 5);
    cmp("lit_p12_period", int'(PERIOD), 12);
    cmp("lit_p12_unlock", int'(LOCKED), 0);
    repeat (6) slow(5, 5);
    cmp("lit_relock", int'(LOCKED), 1);

    slow(5, 6);
    slow(5, 5);
    cmp("lit_p11_period", int'(PERIOD), 11);
    cmp("lit_p11_locked", int'(LOCKED), 1);
    slow(5, 5);

    t0 = tmo_seen;
    repeat (260) begin
      @(negedge CLK);
      CLK_VAL = 1'b0;
    end
    cmp("lit_tmo_once", tmo_seen - t0, 1);
    cmp("lit_tmo_unlock", int'(LOCKED), 0);
    cmp("lit_tmo_period", int'(PERIOD), 10);

    repeat (8) slow(5, 5);
    cmp("lit_relock2", int'(LOCKED), 1);
    slow(5, 2);
    slow(1, 2);
`ifdef CLOCK_PHASE_TRACKER_GLITCH_FILTER_EN
    cmp("lit_glitch_locked", int'(LOCKED), 1);
    cmp("lit_glitch_period", int'(PERIOD), 10);
`else
    cmp("lit_glitch_locked", int'(LOCKED), 0);
    cmp("lit_glitch_period", int'(PERIOD), 7);
`endif
    repeat (3) slow(5, 5);

    for (int i = 0; i < 30; i++)
      slow(5, 4 + int'($urandom_range(0, 2)));
    for (int i = 0; i < 30; i++)
      slow(int'($urandom_range(1, 12)),
           int'($urandom_range(1, 12)));

    repeat (8) slow(5, 5);
    cmp("lit_relock3", int'(LOCKED), 1);
    @(negedge CLK);
    CLK_VAL = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    cmp("lit_async_locked", int'(LOCKED), 0);
    cmp("lit_async_period", int'(PERIOD), 0);
    cmp("lit_async_phase", int'(PHASE), 0);
    cmp("lit_async_high", int'(HIGH_CNT), 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
`ifdef CLOCK_PHASE_TRACKER_GLITCH_FILTER_EN
    @(posedge CLK);
`endif
    #2;
    cmp("lit_release_rise", int'(RISE_PULSE), 1);
    repeat (4) slow(5, 5);
    cmp("lit_post_rst_period", int'(PERIOD), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
